// File: rtl/forth_cpu_pkg.sv
// Shared encodings for the ForthCPU core: instruction fields, register roles
// and the four-phase sequencing enum.
package forth_cpu_pkg;

  localparam logic [1:0] GRP_ALU = 2'b00;
  localparam logic [1:0] GRP_LS  = 2'b01;
  localparam logic [1:0] GRP_JMP = 2'b10;
  localparam logic [1:0] GRP_CTL = 2'b11;

  localparam logic [1:0] ALU_MOV = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_CMP = 2'd3;

  localparam logic [1:0] MODE_RR  = 2'd0;
  localparam logic [1:0] MODE_RU4 = 2'd1;
  localparam logic [1:0] MODE_AU8 = 2'd2;
  localparam logic [1:0] MODE_AS8 = 2'd3;

  localparam logic [2:0] LS_LD  = 3'd0;
  localparam logic [2:0] LS_ST  = 3'd1;
  localparam logic [2:0] LS_LDI = 3'd2;

  localparam logic [3:0] RA = 4'd12;
  localparam logic [3:0] RL = 4'd14;

  localparam logic [1:0] COND_Z = 2'd0;
  localparam logic [1:0] COND_C = 2'd1;
  localparam logic [1:0] COND_S = 2'd2;
  localparam logic [1:0] COND_P = 2'd3;

  typedef enum logic [1:0] {
    PH_FETCH,
    PH_DECODE,
    PH_EXECUTE,
    PH_COMMIT
  } phase_t;

endpackage

// File: rtl/forth_cpu_alu.sv
// Combinational ALU: MOV passes b, ADD/SUB/CMP produce a 17-bit result whose
// top bit is carry (ADD) or borrow (SUB/CMP).
module forth_cpu_alu
  import forth_cpu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        z,
  output logic        c,
  output logic        s,
  output logic        p
);

  logic [16:0] wide;

  always_comb begin
    wide = 17'd0;
    case (op)
      ALU_MOV: wide = {1'b0, b};
      ALU_ADD: wide = {1'b0, a} + {1'b0, b};
      default: wide = {1'b0, a} - {1'b0, b};
    endcase
  end

  assign result = wide[15:0];
  assign z      = (result == 16'h0000);
  assign c      = wide[16];
  assign s      = result[15];
  assign p      = (result != 16'h0000) & ~(^result);

endmodule

// File: rtl/forth_cpu_core.sv
// Four-phase non-pipelined ForthCPU core. Bus strobes are decoded from the
// phase register and gated by RESET so an asserted reset kills them at once.
module forth_cpu_core
  import forth_cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INT0,
  input  logic        INT1,
  input  logic [15:0] DIN,
  output logic [15:0] ADDR_BUF,
  output logic [15:0] DOUT_BUF,
  output logic        RDN_BUF,
  output logic        WRN0_BUF,
  output logic        WRN1_BUF,
  output logic        ABUS_OEN,
  output logic        STOPPED,
  output logic        FETCH,
  output logic        DECODE,
  output logic        EXECUTE,
  output logic        COMMIT
);

  phase_t      phase, phase_nxt;
  logic [15:0] regs [16];
  logic [15:0] pc, ir, a_q, op_q, rb_q, lit_q;
  logic        z_q, c_q, s_q, p_q, stopped;
  logic [1:0]  int0_sync, int1_sync;
  logic        int_unused;

  logic [1:0]  grp, mode;
  logic [3:0]  ra_idx, rb_idx;
  logic        alu_wr, alu_flags, is_ld, is_st, is_ldi, is_jmp, is_halt;
  logic        uses_lit, flag_sel, taken;
  logic [15:0] operand, pc_inc, alu_res;
  logic        alu_z, alu_c, alu_s, alu_p;
  logic        rd, wr;
  logic [15:0] addr, dout;

  // Interrupt inputs are synchronised but not yet acted upon.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      int0_sync <= 2'b00;
      int1_sync <= 2'b00;
    end else begin
      int0_sync <= {int0_sync[0], INT0};
      int1_sync <= {int1_sync[0], INT1};
    end
  end
  assign int_unused = ^{int0_sync[1], int1_sync[1]};

  assign grp       = ir[15:14];
  assign mode      = ir[9:8];
  assign rb_idx    = ir[3:0];
  assign ra_idx    = (grp == GRP_ALU && mode[1]) ? RA : ir[7:4];
  assign alu_wr    = (grp == GRP_ALU) && (ir[13:12] == 2'b00) && (ir[11:10] != ALU_CMP);
  assign alu_flags = (grp == GRP_ALU) && (ir[13:12] == 2'b00) && (ir[11:10] != ALU_MOV);
  assign is_ld     = (grp == GRP_LS) && !ir[13] && (ir[12:10] == LS_LD);
  assign is_st     = (grp == GRP_LS) && !ir[13] && (ir[12:10] == LS_ST);
  assign is_ldi    = (grp == GRP_LS) && !ir[13] && (ir[12:10] == LS_LDI);
  assign is_jmp    = (grp == GRP_JMP);
  assign is_halt   = (grp == GRP_CTL) && (ir[13:12] == 2'b11);
  assign uses_lit  = is_ldi | is_jmp;
  assign pc_inc    = pc + (uses_lit ? 16'd4 : 16'd2);

  always_comb begin
    operand = 16'h0000;
    case (mode)
      MODE_RR:  operand = regs[rb_idx];
      MODE_RU4: operand = {12'h000, ir[3:0]};
      MODE_AU8: operand = {8'h00, ir[7:0]};
      MODE_AS8: operand = {{8{ir[7]}}, ir[7:0]};
      default:  operand = 16'h0000;
    endcase
  end

  always_comb begin
    flag_sel = 1'b0;
    case (ir[12:11])
      COND_Z:  flag_sel = z_q;
      COND_C:  flag_sel = c_q;
      COND_S:  flag_sel = s_q;
      COND_P:  flag_sel = p_q;
      default: flag_sel = 1'b0;
    endcase
  end
  assign taken = ir[10] | (flag_sel ^ ir[13]);

  forth_cpu_alu u_alu (
    .op     (ir[11:10]),
    .a      (a_q),
    .b      (op_q),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c),
    .s      (alu_s),
    .p      (alu_p)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) phase <= PH_FETCH;
    else        phase <= phase_nxt;
  end

  // A halted core parks in FETCH and never leaves it.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_FETCH:   phase_nxt = stopped ? PH_FETCH : PH_DECODE;
      PH_DECODE:  phase_nxt = PH_EXECUTE;
      PH_EXECUTE: phase_nxt = PH_COMMIT;
      PH_COMMIT:  phase_nxt = PH_FETCH;
      default:    phase_nxt = PH_FETCH;
    endcase
  end

  always_comb begin
    rd   = 1'b0;
    wr   = 1'b0;
    addr = 16'h0000;
    dout = 16'h0000;
    case (phase)
      PH_FETCH: if (!stopped) begin
        rd   = 1'b1;
        addr = pc;
      end
      PH_EXECUTE: if (uses_lit) begin
        rd   = 1'b1;
        addr = pc + 16'd2;
      end else if (is_ld) begin
        rd   = 1'b1;
        addr = rb_q;
      end
      PH_COMMIT: if (is_st) begin
        wr   = 1'b1;
        addr = rb_q;
        dout = a_q;
      end
      default: ;
    endcase
  end

  assign ADDR_BUF = addr & 16'hFFFE;
  assign DOUT_BUF = dout;
  assign RDN_BUF  = ~(rd & RESET);
  assign WRN0_BUF = ~(wr & RESET);
  assign WRN1_BUF = ~(wr & RESET);
  assign ABUS_OEN = RDN_BUF & WRN0_BUF & WRN1_BUF;
  assign STOPPED  = stopped | ((phase == PH_COMMIT) && is_halt);
  assign FETCH    = (phase == PH_FETCH);
  assign DECODE   = (phase == PH_DECODE);
  assign EXECUTE  = (phase == PH_EXECUTE);
  assign COMMIT   = (phase == PH_COMMIT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc      <= 16'h0000;
      ir      <= 16'h0000;
      a_q     <= 16'h0000;
      op_q    <= 16'h0000;
      rb_q    <= 16'h0000;
      lit_q   <= 16'h0000;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      p_q     <= 1'b0;
      stopped <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else begin
      case (phase)
        PH_FETCH: if (!stopped) ir <= DIN;
        PH_DECODE: begin
          a_q  <= regs[ra_idx];
          op_q <= operand;
          rb_q <= regs[rb_idx];
        end
        PH_EXECUTE: if (uses_lit | is_ld) lit_q <= DIN;
        PH_COMMIT: begin
          if (alu_wr)          regs[ra_idx] <= alu_res;
          if (is_ld | is_ldi)  regs[ra_idx] <= lit_q;
          if (alu_flags) begin
            z_q <= alu_z;
            c_q <= alu_c;
            s_q <= alu_s;
            p_q <= alu_p;
          end
          if (is_halt) stopped <= 1'b1;
          pc <= (is_jmp && taken) ? lit_q : pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_forth_cpu_core.sv
// Lockstep bench for forth_cpu_core: an instruction-level model predicts every
// bus phase; directed programs cover the listed cases, random programs the rest.
module tb_forth_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        int0 = 1'b0, int1 = 1'b0;
  logic [15:0] din, addr, dout;
  logic        rdn, wrn0, wrn1, oen, stopped, ph_f, ph_d, ph_e, ph_c;

  bit   [15:0] mem  [32768];
  bit   [15:0] mmem [32768];
  logic [15:0] mr [16];
  logic        mz, mc, ms, mp, mhalt;
  logic [15:0] mpc;
  logic        e_rd, e_st;
  logic [15:0] e_rd_addr, e_st_addr, e_st_data;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          n_chk = 0, n_fail = 0, pa = 0;

  always #5 clk = ~clk;
  assign din = mem[addr[15:1]];

  forth_cpu_core dut (
    .CLK(clk), .RESET(rst_n), .INT0(int0), .INT1(int1), .DIN(din),
    .ADDR_BUF(addr), .DOUT_BUF(dout), .RDN_BUF(rdn), .WRN0_BUF(wrn0),
    .WRN1_BUF(wrn1), .ABUS_OEN(oen), .STOPPED(stopped),
    .FETCH(ph_f), .DECODE(ph_d), .EXECUTE(ph_e), .COMMIT(ph_c)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [15:0] w);
    mem[pa] = w;
    pa++;
  endtask

  function automatic logic [15:0] alu_i(input int opc, input int md, input int x, input int y);
    return {2'b00, 4'(opc), 2'(md), 4'(x), 4'(y)};
  endfunction

  function automatic logic [15:0] alu8(input int opc, input int md, input int imm);
    return {2'b00, 4'(opc), 2'(md), 8'(imm)};
  endfunction

  function automatic logic [15:0] ls_i(input int op, input int ra, input int rb);
    return {2'b01, 1'b0, 3'(op), 2'b00, 4'(ra), 4'(rb)};
  endfunction

  task automatic ldi(input int r, input logic [15:0] v);
    emit(ls_i(2, r, 0));
    emit(v);
  endtask

  // MOV R5,#k ; Jcc over one marker store ; the marker appears only if skipped.
  task automatic jump_skip(input int inv, input int cond, input int alw, input int k);
    emit(alu_i(0, 1, 5, k));
    emit({2'b10, 1'(inv), 2'(cond), 1'(alw), 10'h000});
    emit(16'((pa + 2) * 2));
    emit(ls_i(1, 5, 14));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    pa = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
    for (int i = 0; i < 32768; i++) mmem[i] = mem[i];
    {mz, mc, ms, mp, mhalt} = 5'b0;
    mpc = 16'h0000;
    obs_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Instruction-set model: architectural effect plus the bus traffic it implies.
  task automatic model_step();
    logic [15:0] w, lit, opv, a, res, npc, rbv;
    logic [3:0]  ri;
    logic        f, tk;
    int          ai;
    w   = mmem[mpc[15:1]];
    lit = mmem[mpc[15:1] + 15'd1];
    {e_rd, e_st} = 2'b00;
    e_rd_addr = 16'h0; e_st_addr = 16'h0; e_st_data = 16'h0;
    npc = mpc + 16'd2;
    case (w[15:14])
      2'd0: begin
        ri = w[9] ? 4'd12 : w[7:4];
        case (w[9:8])
          2'd0: opv = mr[w[3:0]];
          2'd1: opv = {12'h0, w[3:0]};
          2'd2: opv = {8'h0, w[7:0]};
          default: opv = 16'($signed(w[7:0]));
        endcase
        a = mr[ri];
        if (w[13:10] == 4'd0) mr[ri] = opv;
        else if (w[13:10] <= 4'd3) begin
          if (w[13:10] == 4'd1) begin ai = int'(a) + int'(opv); mc = (ai > 65535); end
          else begin ai = int'(a) - int'(opv); mc = (a < opv); end
          res = ai[15:0];
          mz = (res == 16'h0);
          ms = res[15];
          mp = (res != 16'h0) && ($countones(res) % 2 == 0);
          if (w[13:10] != 4'd3) mr[ri] = res;
        end
      end
      2'd1: if (!w[13]) begin
        rbv = mr[w[3:0]];
        case (w[12:10])
          3'd0: begin e_rd = 1; e_rd_addr = rbv & 16'hFFFE; mr[w[7:4]] = mmem[rbv[15:1]]; end
          3'd1: begin
            e_st = 1; e_st_addr = rbv & 16'hFFFE; e_st_data = mr[w[7:4]];
            mmem[rbv[15:1]] = mr[w[7:4]];
          end
          3'd2: begin e_rd = 1; e_rd_addr = npc & 16'hFFFE; mr[w[7:4]] = lit; npc = mpc + 16'd4; end
          default: ;
        endcase
      end
      2'd2: begin
        case (w[12:11])
          2'd0: f = mz;
          2'd1: f = mc;
          2'd2: f = ms;
          default: f = mp;
        endcase
        e_rd = 1; e_rd_addr = npc & 16'hFFFE;
        tk = w[10] || (f != w[13]);
        npc = tk ? lit : mpc + 16'd4;
      end
      default: if (w[13:12] == 2'b11) mhalt = 1'b1;
    endcase
    mpc = npc;
  endtask

  // Entered at the negedge inside FETCH, leaves at the negedge of the next FETCH.
  task automatic run_instr();
    chk("fetch_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h8);
    chk("fetch_rdn", rdn, 16'h0);
    chk("fetch_addr", addr, mpc & 16'hFFFE);
    chk("fetch_oen", oen, 16'h0);
    model_step();
    @(negedge clk);
    chk("decode_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h4);
    chk("decode_bus", {rdn, wrn0, wrn1, oen}, 16'hF);
    @(negedge clk);
    chk("execute_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h2);
    chk("execute_rdn", rdn, !e_rd);
    if (e_rd) chk("execute_addr", addr, e_rd_addr);
    chk("execute_wrn", {wrn0, wrn1}, 16'h3);
    @(negedge clk);
    chk("commit_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h1);
    chk("commit_wrn", {wrn0, wrn1}, e_st ? 16'h0 : 16'h3);
    chk("commit_rdn", rdn, 16'h1);
    chk("commit_stopped", stopped, mhalt);
    if (e_st) begin
      chk("store_addr", addr, e_st_addr);
      chk("store_data", dout, e_st_data);
    end
    if (!wrn0 && !wrn1) begin
      mem[addr[15:1]] = dout;
      obs_q.push_back(dout);
    end
    @(negedge clk);
  endtask

  task automatic run_prog(input int max_instr);
    for (int n = 0; n < max_instr && !mhalt; n++) run_instr();
  endtask

  task automatic gen_random(input int nwords);
    int k, ls;
    clear_mem();
    while (pa < nwords) begin
      k = $urandom_range(0, 9);
      if (k < 5) emit({2'b00, 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 8'($urandom)});
      else if (k < 7) begin
        ls = $urandom_range(0, 2);
        emit(ls_i(ls, $urandom_range(0, 15), $urandom_range(0, 15)));
        if (ls == 2) emit(16'($urandom));
      end else if (k < 9) begin
        emit({2'b10, 4'($urandom), 10'h000});
        emit(16'($urandom_range(0, nwords - 1) * 2));
      end else emit({2'b11, 2'($urandom_range(0, 2)), 12'($urandom)});
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h8);
    chk("reset_stopped", stopped, 16'h0);
    chk("reset_strobes", {rdn, wrn0, wrn1, oen}, 16'hF);
    chk("reset_addr", addr, 16'h0000);
    chk("reset_dout", dout, 16'h0000);

    // Directed program following the listed cases.
    clear_mem();
    emit(alu8(0, 3, 8'hAF)); ldi(0, 16'hFAAF); emit(ls_i(1, 12, 0));
    emit(alu8(0, 2, 8'hFA)); emit(ls_i(1, 12, 0));
    ldi(14, 16'h4040); ldi(1, 16'h1111); ldi(0, 16'h4444);
    emit(alu_i(1, 0, 0, 1)); emit(ls_i(1, 0, 14));
    ldi(0, 16'h4444); emit(alu_i(1, 1, 0, 5)); emit(ls_i(1, 0, 14));
    ldi(12, 16'h4444); emit(alu8(1, 3, 8'h82)); emit(ls_i(1, 12, 14));
    ldi(12, 16'h4444);
    emit(alu_i(3, 0, 12, 1));  emit(ls_i(1, 12, 14));
    emit(alu_i(3, 1, 12, 10)); emit(ls_i(1, 12, 14));
    emit(alu8(3, 2, 8'hAA));   emit(ls_i(1, 12, 14));
    emit(alu8(3, 3, 8'hFF));   emit(ls_i(1, 12, 14));
    for (int c = 0; c < 4; c++) begin
      ldi(12, (c % 2) ? 16'h1110 : 16'h1111);
      emit(alu_i((c < 2) ? 2 : 3, 0, 12, 1));
      emit(ls_i(1, 12, 14));
      for (int cond = 0; cond < 4; cond++) jump_skip(0, cond, 0, c * 4 + cond);
    end
    jump_skip(1, 0, 0, 14);
    jump_skip(0, 0, 1, 15);
    emit(ls_i(0, 6, 14)); emit(ls_i(1, 6, 0));
    emit(16'hF000);
    exp_q = '{16'hFFAF, 16'h00FA, 16'h5555, 16'h4449, 16'h43C6, 16'h4444, 16'h4444,
              16'h4444, 16'h4444, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF,
              16'h0004, 16'h1111, 16'h0009, 16'h000A, 16'h000B, 16'h1110, 16'h000C,
              16'h000C};
    model_reset();
    do_reset();
    run_prog(200);
    chk("dir_halted", mhalt, 16'h1);
    chk("dir_store_count", 16'(obs_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("dir_store_%0d", i), obs_q[i], exp_q[i]);
    repeat (3) begin
      chk("halt_stopped", stopped, 16'h1);
      chk("halt_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h8);
      chk("halt_bus", {rdn, wrn0, wrn1, oen}, 16'hF);
      @(negedge clk);
    end

    // Reset dropped while a store is on the bus.
    clear_mem();
    ldi(3, 16'h1234); ldi(4, 16'h0100); emit(ls_i(1, 3, 4)); emit(16'hF000);
    model_reset();
    do_reset();
    run_instr();
    run_instr();
    repeat (3) @(negedge clk);
    chk("abort_pre_wrn", {wrn0, wrn1}, 16'h0);
    rst_n = 1'b0;
    #1;
    chk("abort_wrn", {wrn0, wrn1, oen}, 16'h7);
    chk("abort_phase", {ph_f, ph_d, ph_e, ph_c}, 16'h8);
    chk("abort_addr", addr, 16'h0000);
    chk("abort_dout", dout, 16'h0000);
    model_reset();
    do_reset();
    run_prog(10);
    chk("abort_rerun_stores", 16'(obs_q.size()), 16'h1);

    // Random programs checked phase by phase against the model.
    for (int r = 0; r < 2; r++) begin
      int0 = 1'($urandom);
      int1 = 1'($urandom);
      gen_random(256);
      model_reset();
      do_reset();
      run_prog(300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
